// File: rtl/fmul_norm_round.sv
// -----------------------------------------------------------------------------
// fmul_norm_round
//
// Normalise-and-round stage of the floating-point multiplier pipeline. It takes
// the raw double-width significand product, the result sign and the biased,
// not yet normalised exponent. It produces a packed IEEE-754 result with
// overflow, underflow and inexact flags.
//
// The stage is a two-deep valid/ready pipeline:
//   stage A : normalise the product. It registers mantissa, guard, sticky,
//             exponent and the zero flag.
//   stage B : round, detect exceptions, pack. It registers the outputs.
//
// Configuration macro:
//   FMUL_RNE_EN  defined   -> round-to-nearest-even
//                undefined -> truncate. There is no incrementer and no carry
//                             path. inexact still reports G|S.
//
// Parameters:
//   EW  exponent field width (8 single, 11 double)
//   MW  fraction field width (23 single, 52 double)
//   PW  product width 2*(MW+1)        (derived)
//   XW  signed exponent width EW+2    (derived)
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   stage can accept a beat (combinational from out_ready)
//   in_sign    result sign
//   in_exp     signed biased exponent ea+eb-bias, before normalisation
//   in_prod    unsigned significand product (1.x * 1.x)
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_res    packed {sign, exponent, fraction}
//   out_ovf    result overflowed to infinity
//   out_unf    result flushed to zero
//   out_inx    result inexact
// -----------------------------------------------------------------------------
module fmul_norm_round #(
    parameter  int EW = 8,
    parameter  int MW = 23,
    localparam int PW = 2 * (MW + 1),
    localparam int XW = EW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic signed [XW-1:0] in_exp,
    input  logic [PW-1:0]        in_prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EW+MW:0]       out_res,
    output logic                 out_ovf,
    output logic                 out_unf,
    output logic                 out_inx
);

    localparam int                     RW       = 1 + EW + MW;
    localparam logic signed [XW-1:0]   EXP_INF  = XW'((1 << EW) - 1);
    localparam logic signed [XW-1:0]   EXP_ZERO = '0;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_va;
    logic r_vb;
    logic w_adv_a;
    logic w_adv_b;

    assign w_adv_b  = !r_vb || out_ready;
    assign w_adv_a  = !r_va || w_adv_b;
    assign in_ready = w_adv_a && !rst;

    // ------------------------------------------------------------------
    // Stage A: normalise
    // ------------------------------------------------------------------
    // When the top product bit is clear, shift left one place so that the
    // same window (mantissa, guard, sticky) serves both cases.
    logic [PW-1:0]        w_norm;
    logic [MW:0]          w_mant_a;
    logic                 w_g_a;
    logic                 w_s_a;
    logic signed [XW-1:0] w_exp_a;
    logic                 w_zero_a;

    assign w_norm   = in_prod[PW-1] ? in_prod : {in_prod[PW-2:0], 1'b0};
    assign w_mant_a = w_norm[PW-1 -: MW+1];
    assign w_g_a    = w_norm[PW-MW-2];
    assign w_s_a    = |w_norm[PW-MW-3:0];
    assign w_exp_a  = in_exp + {{(XW-1){1'b0}}, in_prod[PW-1]};
    assign w_zero_a = (in_prod == '0);

    logic                 r_a_sign;
    logic signed [XW-1:0] r_a_exp;
    logic [MW:0]          r_a_mant;
    logic                 r_a_g;
    logic                 r_a_s;
    logic                 r_a_zero;

    // NOTE: payload registers carry no reset. r_va qualifies them, so their
    // contents after reset are never observed, and leaving out the reset
    // keeps the wide datapath flops simple.
    always_ff @(posedge clk) begin
        if (w_adv_a) begin
            r_a_sign <= in_sign;
            r_a_exp  <= w_exp_a;
            r_a_mant <= w_mant_a;
            r_a_g    <= w_g_a;
            r_a_s    <= w_s_a;
            r_a_zero <= w_zero_a;
        end
    end

    // ------------------------------------------------------------------
    // Stage B: round, exceptions, pack
    // ------------------------------------------------------------------
    logic [MW+1:0]        w_rm;
    logic signed [XW-1:0] w_exp_b;

`ifdef FMUL_RNE_EN
    logic w_inc;
    // Round half to even. Increment above the halfway point, or exactly at
    // the halfway point when the kept LSB is odd.
    assign w_inc = r_a_g && (r_a_s || r_a_mant[0]);
    assign w_rm  = {1'b0, r_a_mant} + {{(MW+1){1'b0}}, w_inc};
`else
    assign w_rm  = {1'b0, r_a_mant};
`endif

    // A carry out of the mantissa leaves 10.000..0. The fraction bits are
    // already zero, so only the exponent needs a bump.
    assign w_exp_b = r_a_exp + {{(XW-1){1'b0}}, w_rm[MW+1]};

    // In range, the hidden bit is implied by the exponent field.
    logic w_unused_lead;
    assign w_unused_lead = w_rm[MW];

    logic [RW-1:0] w_res;
    logic          w_ovf;
    logic          w_unf;
    logic          w_inx;

    // NOTE: every output of this block gets a default first. A branch that
    // forgets a signal then cannot infer a latch.
    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = 1'b0;
        if (r_a_zero) begin
            w_res = {r_a_sign, {(EW+MW){1'b0}}};
        end else if (w_exp_b >= EXP_INF) begin
            w_res = {r_a_sign, {EW{1'b1}}, {MW{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_exp_b <= EXP_ZERO) begin
            // Flush to zero: this block produces no subnormals.
            w_res = {r_a_sign, {(EW+MW){1'b0}}};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end else begin
            w_res = {r_a_sign, w_exp_b[EW-1:0], w_rm[MW-1:0]};
            w_inx = r_a_g || r_a_s;
        end
    end

    // ------------------------------------------------------------------
    // Valids and output registers
    // ------------------------------------------------------------------
    // NOTE: all state updates use non-blocking assignment. Every register
    // then samples pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_va    <= 1'b0;
            r_vb    <= 1'b0;
            out_res <= '0;
            out_ovf <= 1'b0;
            out_unf <= 1'b0;
            out_inx <= 1'b0;
        end else begin
            if (w_adv_a) begin
                r_va <= in_valid;
            end
            // Outputs hold while stalled because they only load on advance.
            if (w_adv_b) begin
                r_vb    <= r_va;
                out_res <= w_res;
                out_ovf <= w_ovf;
                out_unf <= w_unf;
                out_inx <= w_inx;
            end
        end
    end

    assign out_valid = r_vb;

endmodule

// File: tb/tb_fmul_norm_round.sv
// -----------------------------------------------------------------------------
// tb_fmul_norm_round
//
// Directed bench for fmul_norm_round with EW=8, MW=23. Expected results come
// from a table of hand-derived values, with separate round-to-nearest-even
// and truncation columns. Each accepted beat pushes its expected result onto
// a queue. A monitor pops the queue and compares on every output transfer.
// -----------------------------------------------------------------------------
module tb_fmul_norm_round;

    localparam int EW = 8;
    localparam int MW = 23;
    localparam int PW = 2 * (MW + 1);
    localparam int XW = EW + 2;
    localparam int RW = 1 + EW + MW;

`ifdef FMUL_RNE_EN
    localparam bit RNE_EN = 1'b1;
`else
    localparam bit RNE_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic signed [XW-1:0] in_exp;
    logic [PW-1:0]        in_prod;
    logic                 out_valid;
    logic                 out_ready;
    logic [RW-1:0]        out_res;
    logic                 out_ovf;
    logic                 out_unf;
    logic                 out_inx;

    fmul_norm_round #(.EW(EW), .MW(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_inx   (out_inx)
    );

    always #5 clk = ~clk;

    typedef struct {
        string                name;
        logic                 sign;
        logic signed [XW-1:0] exp;
        logic [PW-1:0]        prod;
        logic [RW-1:0]        res;
        logic                 ovf;
        logic                 unf;
        logic                 inx;
    } vec_t;

    vec_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_sent   = 0;
    int   n_out    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic s, input int e,
                                input logic [PW-1:0] p, input logic [RW-1:0] r_rne,
                                input logic [RW-1:0] r_trn, input logic o,
                                input logic u, input logic x);
        vec_t v;
        v.name = n;
        v.sign = s;
        v.exp  = XW'(e);
        v.prod = p;
        v.res  = RNE_EN ? r_rne : r_trn;
        v.ovf  = o;
        v.unf  = u;
        v.inx  = x;
        return v;
    endfunction

    // Called just after a falling edge. It offers one beat and waits, with
    // a bound, for in_ready. It pushes the expected result when the beat
    // will transfer on the next rising edge, then returns at the following
    // falling edge with in_valid low.
    task automatic offer(input vec_t v, output int waited);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_sign  = v.sign;
        in_exp   = v.exp;
        in_prod  = v.prod;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        if (in_ready) begin
            q.push_back(v);
            n_sent++;
        end else begin
            check({v.name, "_accept_timeout"}, 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(q.size()), 64'd0);
    endtask

    // Output monitor: samples 2 time units after each falling edge, clear of
    // the rising edge where the transfer takes place.
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            n_out++;
            n_checks++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out: observed res=%0h expected no output", out_res);
            end
            if (q.size() != 0) begin
                vec_t e;
                e = q.pop_front();
                check(e.name, 64'({out_res, out_ovf, out_unf, out_inx}),
                      64'({e.res, e.ovf, e.unf, e.inx}));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v[$];
        int   w;

        v.push_back(mk("normal_2p25",  0, 127, 48'h900000000000, 32'h40100000, 32'h40100000, 0, 0, 0));
        v.push_back(mk("tie_even",     0, 127, 48'h400000400000, 32'h3F800000, 32'h3F800000, 0, 0, 1));
        v.push_back(mk("tie_odd",      0, 127, 48'h400000C00000, 32'h3F800002, 32'h3F800001, 0, 0, 1));
        v.push_back(mk("round_carry",  0, 127, 48'h7FFFFFC00000, 32'h40000000, 32'h3FFFFFFF, 0, 0, 1));
        v.push_back(mk("overflow",     1, 254, 48'h800000000000, 32'hFF800000, 32'hFF800000, 1, 0, 1));
        v.push_back(mk("underflow",    0, 0,   48'h400000000000, 32'h00000000, 32'h00000000, 0, 1, 1));
        v.push_back(mk("zero",         0, 200, 48'h000000000000, 32'h00000000, 32'h00000000, 0, 0, 0));
        v.push_back(mk("max_normal",   0, 253, 48'h800000000000, 32'h7F000000, 32'h7F000000, 0, 0, 0));
        v.push_back(mk("min_normal",   1, 1,   48'h400000000000, 32'h80800000, 32'h80800000, 0, 0, 0));
        v.push_back(mk("carry_to_inf", 0, 254, 48'h7FFFFFC00000, 32'h7F800000, 32'h7F7FFFFF, RNE_EN, 0, 1));
        v.push_back(mk("neg_exp",      0, -5,  48'hC00000000000, 32'h00000000, 32'h00000000, 0, 1, 1));
        v.push_back(mk("above_half",   0, 127, 48'h400000600000, 32'h3F800001, 32'h3F800000, 0, 0, 1));

        // Reset state.
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_prod   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs",   64'({out_res, out_ovf, out_unf, out_inx}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Latency: offered in cycle c, out_valid visible in cycle c+2.
        offer(v[0], w);
        #1;
        check("lat_cycle1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("lat_cycle2_out_valid", 64'(out_valid), 64'd1);
        @(negedge clk);
        drain("latency");

        // Full-rate stream: every offer is accepted with no wait.
        for (int i = 1; i < v.size(); i++) begin
            offer(v[i], w);
            check({v[i].name, "_no_wait"}, 64'(w), 64'd0);
        end
        drain("stream");

        // Backpressure: two beats fill the pipe and then in_ready falls.
        out_ready = 1'b0;
        offer(v[0], w);
        offer(v[1], w);
        in_valid = 1'b1;
        in_sign  = v[2].sign;
        in_exp   = v[2].exp;
        in_prod  = v[2].prod;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
            check("bp_out_stable", 64'({out_res, out_ovf, out_unf, out_inx}),
                  64'({q[0].res, q[0].ovf, q[0].unf, q[0].inx}));
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        out_ready = 1'b1;
        offer(v[2], w);
        check("bp_in_ready_comb", 64'(w), 64'd0);
        offer(v[3], w);
        drain("backpressure");

        // Reset mid-stream with two beats held.
        out_ready = 1'b0;
        offer(v[4], w);
        offer(v[7], w);
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", 64'(in_ready), 64'd0);
        n_sent = n_sent - q.size();
        q.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        offer(v[8], w);
        drain("after_reset");
        repeat (5) @(negedge clk);
        check("beat_count", 64'(n_out), 64'(n_sent));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
